// File: rtl/dual_issue_fetch_queue_pkg.sv
// Shared types for the dual-issue fetch queue: instruction word, fetched pair,
// the NOP filler for empty issue slots and the in-order pop-count rule.
package fetch_pkg;

    typedef logic [31:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        instr_t hi;
        instr_t lo;
    } fetch_pair_t;

    // Slot 1 can only retire together with slot 0, never ahead of it.
    function automatic logic [1:0] pop_count(input logic f1, input logic f2,
                                             input logic dep, input logic v0,
                                             input logic v1);
        if (f1 || !v0) return 2'd0;
        if (f2 || dep || !v1) return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/dual_issue_fetch_queue_if.sv
// Bundle of the memory, redirect, scheduler-feedback and issue-slot signals.
// FETCHQ_PERF_EN adds the issued_count / empty_cycles observation counters.
interface dual_issue_fetch_queue_if;
    import fetch_pkg::*;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    fetch_pair_t mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        freeze1;
    logic        freeze2;
    logic        dependency_on_ins2;
    instr_t      instruction0;
    instr_t      instruction1;
    logic        valid0;
    logic        valid1;
    logic        nothing_filled;
`ifdef FETCHQ_PERF_EN
    logic [31:0] issued_count;
    logic [31:0] empty_cycles;

    modport master (
        output mem_req, mem_addr, instruction0, instruction1, valid0, valid1,
               nothing_filled, issued_count, empty_cycles,
        input  mem_valid, mem_rdata, redirect, redirect_pc, freeze1, freeze2,
               dependency_on_ins2
    );
    modport slave (
        input  mem_req, mem_addr, instruction0, instruction1, valid0, valid1,
               nothing_filled, issued_count, empty_cycles,
        output mem_valid, mem_rdata, redirect, redirect_pc, freeze1, freeze2,
               dependency_on_ins2
    );
`else
    modport master (
        output mem_req, mem_addr, instruction0, instruction1, valid0, valid1,
               nothing_filled,
        input  mem_valid, mem_rdata, redirect, redirect_pc, freeze1, freeze2,
               dependency_on_ins2
    );
    modport slave (
        input  mem_req, mem_addr, instruction0, instruction1, valid0, valid1,
               nothing_filled,
        output mem_valid, mem_rdata, redirect, redirect_pc, freeze1, freeze2,
               dependency_on_ins2
    );
`endif

endinterface

// File: rtl/dual_issue_fetch_queue_fifo.sv
// Circular word buffer: up to two pushes and two pops per cycle, with a flush
// that wins over both. Exposes the two oldest entries and the fill count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [1:0]    push_cnt_i,
    input  instr_t        push0_i,
    input  instr_t        push1_i,
    input  logic [1:0]    pop_cnt_i,
    output instr_t        head0,
    output instr_t        head1,
    output logic [CW-1:0] count
);

    instr_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]      head_nxt, tail_nxt;
    logic [CW-1:0]      count_q, count_d;

    assign head_nxt = head_q + PW'(1);
    assign tail_nxt = tail_q + PW'(1);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_cnt_i != 2'd0) mem_d[tail_q]   = push0_i;
            if (push_cnt_i == 2'd2) mem_d[tail_nxt] = push1_i;
            head_d  = head_q + PW'(pop_cnt_i);
            tail_d  = tail_q + PW'(push_cnt_i);
            count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
    end

    // Payload needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head0 = mem_q[head_q];
    assign head1 = mem_q[head_nxt];
    assign count = count_q;

endmodule

// File: rtl/dual_issue_fetch_queue.sv
// Fetch queue feeding the dual-issue scheduler: one outstanding 64-bit fetch,
// redirect flush with stale-response discard. FETCHQ_PERF_EN adds counters.
module dual_issue_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    dual_issue_fetch_queue_if.master  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;

    logic [CW-1:0] count;
    instr_t        head0, head1;
    logic          valid0, valid1, room;
    logic          mem_req, resp, accept;
    logic [1:0]    push_cnt, pop_cnt;
    instr_t        push0;

    assign valid0 = (count != '0);
    assign valid1 = (count >= CW'(2));
    assign room   = (count <= CW'(DEPTH - 2));

    // Held low through reset even though the flags already read idle.
    assign mem_req = !rst && !outstanding_q && !bus.redirect && room;

    // A strobe with nothing outstanding is stray and ignored.
    assign resp   = bus.mem_valid && outstanding_q;
    assign accept = resp && !discard_q && !bus.redirect;

    assign push_cnt = accept ? (fetch_pc_q[2] ? 2'd1 : 2'd2) : 2'd0;
    assign push0    = fetch_pc_q[2] ? bus.mem_rdata.hi : bus.mem_rdata.lo;
    assign pop_cnt  = bus.redirect ? 2'd0
                    : pop_count(bus.freeze1, bus.freeze2, bus.dependency_on_ins2,
                                valid0, valid1);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + (fetch_pc_q[2] ? 32'd4 : 32'd8);
        end

        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        if (mem_req) outstanding_d = 1'b1;

        // A response landing in the redirect cycle is dropped directly.
        if (bus.redirect && outstanding_q && !bus.mem_valid) discard_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.redirect),
        .push_cnt_i (push_cnt),
        .push0_i    (push0),
        .push1_i    (bus.mem_rdata.hi),
        .pop_cnt_i  (pop_cnt),
        .head0      (head0),
        .head1      (head1),
        .count      (count)
    );

    assign bus.mem_req        = mem_req;
    assign bus.mem_addr       = fetch_pc_q & ~32'h7;
    assign bus.instruction0   = valid0 ? head0 : NOP_INSTR;
    assign bus.instruction1   = valid1 ? head1 : NOP_INSTR;
    assign bus.valid0         = valid0;
    assign bus.valid1         = valid1;
    assign bus.nothing_filled = !valid0;

`ifdef FETCHQ_PERF_EN
    logic [31:0] issued_q, issued_d, empty_q, empty_d;

    assign issued_d = issued_q + 32'(pop_cnt);
    assign empty_d  = empty_q + 32'(!valid0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            empty_q  <= '0;
        end else begin
            issued_q <= issued_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.issued_count = issued_q;
    assign bus.empty_cycles = empty_q;
`endif

endmodule
